// File: rtl/icsp_loader_pkg.sv
// Shared definitions for the ICSP loader: default widths, host opcodes and sequencer states.
package icsp_loader_pkg;

    localparam int DEF_PC_WIDTH    = 9;
    localparam int DEF_INST_WIDTH  = 12;
    localparam int DEF_PROG_CYCLES = 8;
    localparam int DEF_MAX_PULSES  = 25;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_ENTER   = 3'd1,
        OP_EXIT    = 3'd2,
        OP_LOAD    = 3'd3,
        OP_PROG    = 3'd4,
        OP_READ    = 3'd5,
        OP_INC     = 3'd6,
        OP_RSTADDR = 3'd7
    } cmdOpE;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_PULSE  = 2'd2,
        ST_VERIFY = 2'd3
    } loaderStateE;

endpackage

// File: rtl/icsp_loader_prog_pulse_timer.sv
// Programming-pulse timer: a start loads it, it runs PROG_CYCLES cycles and flags
// the final one with a single-cycle done.
module prog_pulse_timer #(
    parameter int PROG_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam logic [7:0] LAST_CYC = 8'(PROG_CYCLES - 1);

    logic [7:0] cycCnt;
    logic       running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycCnt  <= '0;
            running <= 1'b0;
        end else if (start) begin
            cycCnt  <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (cycCnt == LAST_CYC) begin
                running <= 1'b0;
            end else begin
                cycCnt <= cycCnt + 8'd1;
            end
        end
    end

    assign done = running && (cycCnt == LAST_CYC);

endmodule

// File: rtl/icsp_loader.sv
// ICSP sequencer: holds the core in reset while a host streams commands, and
// programs words with timed pulses verified by read-back with bounded retries.
//
// state  | meaning
// RUN    | core running, only ENTER/NOP accepted
// IDLE   | programming mode, waiting for host command
// PULSE  | pm_we asserted for PROG_CYCLES cycles
// VERIFY | single cycle comparing read-back against data latch
module icsp_loader
    import icsp_loader_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INST_WIDTH  = DEF_INST_WIDTH,
    parameter int PROG_CYCLES = DEF_PROG_CYCLES,
    parameter int MAX_PULSES  = DEF_MAX_PULSES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [INST_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [INST_WIDTH-1:0] rsp_data,
    output logic [PC_WIDTH-1:0]   pm_addr,
    output logic [INST_WIDTH-1:0] pm_wdata,
    output logic                  pm_we,
    input  logic [INST_WIDTH-1:0] pm_rdata,
    output logic                  core_rst_n,
    output logic                  busy
);

    loaderStateE           state;
    logic                  progMode;
    logic [PC_WIDTH-1:0]   addr;
    logic [INST_WIDTH-1:0] dataLatch;
    logic [7:0]            pulseCnt;
    logic                  pmWe;
    logic                  rspValid;
    logic                  rspErr;
    logic [INST_WIDTH-1:0] rspData;

    cmdOpE op;
    logic  cmdFire;
    logic  verifyOk;
    logic  canRetry;
    logic  timerStart;
    logic  timerDone;

    assign op         = cmdOpE'(cmd_op);
    assign cmdFire    = cmd_valid && cmd_ready;
    assign verifyOk   = (pm_rdata == dataLatch);
    assign canRetry   = (pulseCnt < 8'(MAX_PULSES));
    assign timerStart = ((state == ST_IDLE) && cmdFire && (op == OP_PROG)) ||
                        ((state == ST_VERIFY) && !verifyOk && canRetry);

    prog_pulse_timer #(
        .PROG_CYCLES(PROG_CYCLES)
    ) uTimer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(timerStart),
        .done (timerDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            progMode  <= 1'b0;
            addr      <= '0;
            dataLatch <= '0;
            pulseCnt  <= '0;
            pmWe      <= 1'b0;
            rspValid  <= 1'b0;
            rspErr    <= 1'b0;
            rspData   <= '0;
        end else begin
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            rspData  <= '0;
            case (state)
                ST_RUN: begin
                    if (cmdFire) begin
                        rspValid <= 1'b1;
                        case (op)
                            OP_ENTER: begin
                                progMode <= 1'b1;
                                addr     <= '0;
                                state    <= ST_IDLE;
                            end
                            OP_NOP:  ;
                            default: rspErr <= 1'b1;
                        endcase
                    end
                end
                ST_IDLE: begin
                    if (cmdFire) begin
                        rspValid <= 1'b1;
                        case (op)
                            OP_NOP, OP_ENTER: ;
                            OP_LOAD:    dataLatch <= cmd_data;
                            OP_READ:    rspData   <= pm_rdata;
                            OP_INC:     addr      <= addr + PC_WIDTH'(1);
                            OP_RSTADDR: addr      <= '0;
                            OP_EXIT: begin
                                progMode <= 1'b0;
                                state    <= ST_RUN;
                            end
                            OP_PROG: begin
                                // PROG answers only after verification completes
                                rspValid <= 1'b0;
                                pulseCnt <= 8'd1;
                                pmWe     <= 1'b1;
                                state    <= ST_PULSE;
                            end
                        endcase
                    end
                end
                ST_PULSE: begin
                    if (timerDone) begin
                        pmWe  <= 1'b0;
                        state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (verifyOk) begin
                        rspValid <= 1'b1;
                        rspData  <= INST_WIDTH'(pulseCnt);
                        state    <= ST_IDLE;
                    end else if (canRetry) begin
                        pulseCnt <= pulseCnt + 8'd1;
                        pmWe     <= 1'b1;
                        state    <= ST_PULSE;
                    end else begin
                        rspValid <= 1'b1;
                        rspErr   <= 1'b1;
                        rspData  <= INST_WIDTH'(pulseCnt);
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy       = (state == ST_PULSE) || (state == ST_VERIFY);
    assign cmd_ready  = !busy;
    assign pm_we      = pmWe;
    assign pm_addr    = addr;
    assign pm_wdata   = dataLatch;
    assign rsp_valid  = rspValid;
    assign rsp_err    = rspErr;
    assign rsp_data   = rspData;
    assign core_rst_n = rst_n & ~progMode;

endmodule

// File: tb/tb_icsp_loader.sv
// Directed bench for icsp_loader: transaction-level model of the host protocol
// and a program-memory model with configurable write failures.
module tb_icsp_loader;

    localparam int P    = 8;
    localparam int MAXP = 25;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_ENTER   = 3'd1;
    localparam logic [2:0] OP_EXIT    = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_PROG    = 3'd4;
    localparam logic [2:0] OP_READ    = 3'd5;
    localparam logic [2:0] OP_INC     = 3'd6;
    localparam logic [2:0] OP_RSTADDR = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [11:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic [11:0] rsp_data;
    logic [8:0]  pm_addr;
    logic [11:0] pm_wdata;
    logic        pm_we;
    logic [11:0] pm_rdata;
    logic        core_rst_n;
    logic        busy;

    always #5 clk = ~clk;

    icsp_loader #(
        .PC_WIDTH(9), .INST_WIDTH(12), .PROG_CYCLES(P), .MAX_PULSES(MAXP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .pm_addr(pm_addr), .pm_wdata(pm_wdata), .pm_we(pm_we), .pm_rdata(pm_rdata),
        .core_rst_n(core_rst_n), .busy(busy)
    );

    // program memory model: optionally ignores the first ignoreN pulses, or reads stuck at all-ones
    logic [11:0] mem [0:511] = '{default: 12'h000};
    logic        stuck   = 1'b0;
    int          ignoreN = 0;
    int          pulseBase = 0;
    int          pulseNum  = 0;
    int          weCount   = 0;
    logic        weQ       = 1'b0;
    int          cyc       = 0;

    assign pm_rdata = stuck ? 12'hFFF : mem[pm_addr];

    always @(posedge clk) begin
        if (pm_we) begin
            if (!weQ) pulseNum = pulseNum + 1;
            weCount = weCount + 1;
            if (!stuck && (pulseNum - pulseBase) > ignoreN) mem[pm_addr] <= pm_wdata;
        end
        weQ = pm_we;
        cyc <= cyc + 1;
    end

    typedef struct {
        logic        err;
        logic [11:0] data;
    } rspT;

    rspT         expRsp [int];
    logic        modelProg  = 1'b0;
    int          modelAddr  = 0;
    logic [11:0] modelLatch = 12'h000;
    int          progAcc    = -100;
    int          progN      = 0;
    int          nVec       = 0;
    int          nErr       = 0;
    int          lastRspCyc = -1;
    logic        lastRspErr = 1'b0;
    logic [11:0] lastRspData = 12'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-cycle comparison of every output against the model; called at each falling edge
    task automatic cycleCheck();
        int   d;
        logic eBusy;
        logic eWe;
        d     = cyc - progAcc - 1;
        eBusy = (progN > 0) && (d >= 0) && (d < progN * (P + 1));
        eWe   = eBusy && ((d % (P + 1)) < P);
        chk("pm_we", 32'(pm_we), 32'(eWe));
        chk("busy", 32'(busy), 32'(eBusy));
        chk("cmd_ready", 32'(cmd_ready), 32'(!eBusy));
        chk("pm_addr", 32'(pm_addr), 32'(modelAddr));
        chk("pm_wdata", 32'(pm_wdata), 32'(modelLatch));
        chk("core_rst_n", 32'(core_rst_n), 32'(rst_n & ~modelProg));
        if (expRsp.exists(cyc)) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_err", 32'(rsp_err), 32'(expRsp[cyc].err));
            chk("rsp_data", 32'(rsp_data), 32'(expRsp[cyc].data));
            expRsp.delete(cyc);
        end else begin
            chk("rsp_valid quiet", 32'(rsp_valid), 32'd0);
        end
        if (rsp_valid) begin
            lastRspCyc  = cyc;
            lastRspErr  = rsp_err;
            lastRspData = rsp_data;
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cycleCheck();
    endtask

    // non-PROG command: drive at the current falling edge, accepted at the next rising edge
    task automatic sendCmd(input logic [2:0] op, input logic [11:0] data);
        rspT r;
        r.err  = 1'b0;
        r.data = 12'h000;
        if (!modelProg) begin
            if (op != OP_NOP && op != OP_ENTER) r.err = 1'b1;
        end else if (op == OP_READ) begin
            r.data = stuck ? 12'hFFF : mem[modelAddr];
        end
        expRsp[cyc + 1] = r;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!modelProg) begin
            if (op == OP_ENTER) begin
                modelProg = 1'b1;
                modelAddr = 0;
            end
        end else begin
            case (op)
                OP_LOAD:    modelLatch = data;
                OP_INC:     modelAddr  = (modelAddr + 1) % 512;
                OP_RSTADDR: modelAddr  = 0;
                OP_EXIT:    modelProg  = 1'b0;
                default: ;
            endcase
        end
        cycleCheck();
    endtask

    function automatic void progExpect(output int n, output logic err);
        logic [11:0] cur;
        cur = stuck ? 12'hFFF : mem[modelAddr];
        if (cur == modelLatch) begin
            n = 1; err = 1'b0;
        end else if (!stuck && ignoreN + 1 <= MAXP) begin
            n = ignoreN + 1; err = 1'b0;
        end else begin
            n = MAXP; err = 1'b1;
        end
    endfunction

    // PROG in IDLE; optionally keeps cmd_valid high with an INC pending while busy
    task automatic progCmd(input logic hold, output int acc, output int weUsed);
        int   n;
        logic err;
        rspT  r;
        int   weBase;
        progExpect(n, err);
        acc    = cyc;
        r.err  = err;
        r.data = 12'(n);
        expRsp[acc + n * (P + 1) + 1] = r;
        pulseBase = pulseNum;
        weBase    = weCount;
        cmd_valid = 1'b1;
        cmd_op    = OP_PROG;
        cmd_data  = 12'h000;
        @(negedge clk);
        cmd_valid = hold;
        cmd_op    = OP_INC;
        progAcc   = acc;
        progN     = n;
        cycleCheck();
        repeat (n * (P + 1)) nextCycle();
        cmd_valid = 1'b0;
        weUsed = weCount - weBase;
    endtask

    int acc;
    int weUsed;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 12'h000;
        repeat (3) nextCycle();
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset pm_we", 32'(pm_we), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset pm_addr", 32'(pm_addr), 32'h000);
        rst_n = 1'b1;
        nextCycle();
        chk("run core_rst_n", 32'(core_rst_n), 32'd1);

        // RUN: READ rejected, ENTER puts the core in reset next cycle
        sendCmd(OP_READ, 12'h000);
        chk("run read err", 32'(lastRspErr), 32'd1);
        chk("run read core_rst_n", 32'(core_rst_n), 32'd1);
        sendCmd(OP_ENTER, 12'h000);
        chk("enter core_rst_n", 32'(core_rst_n), 32'd0);
        chk("enter err", 32'(lastRspErr), 32'd0);

        // first-pulse success
        sendCmd(OP_LOAD, 12'hA5C);
        progCmd(1'b0, acc, weUsed);
        chk("prog1 latency", 32'(lastRspCyc - acc), 32'd10);
        chk("prog1 we cycles", 32'(weUsed), 32'd8);
        chk("prog1 data", 32'(lastRspData), 32'd1);
        chk("prog1 err", 32'(lastRspErr), 32'd0);
        sendCmd(OP_READ, 12'h000);
        chk("readback", 32'(lastRspData), 32'hA5C);

        // two ignored pulses, third one sticks
        sendCmd(OP_INC, 12'h000);
        sendCmd(OP_LOAD, 12'h123);
        ignoreN = 2;
        progCmd(1'b0, acc, weUsed);
        ignoreN = 0;
        chk("retry latency", 32'(lastRspCyc - acc), 32'd28);
        chk("retry we cycles", 32'(weUsed), 32'd24);
        chk("retry data", 32'(lastRspData), 32'd3);
        chk("retry err", 32'(lastRspErr), 32'd0);

        // stuck memory exhausts the pulse budget
        sendCmd(OP_INC, 12'h000);
        sendCmd(OP_LOAD, 12'h0F0);
        stuck = 1'b1;
        progCmd(1'b0, acc, weUsed);
        stuck = 1'b0;
        chk("stuck we cycles", 32'(weUsed), 32'd200);
        chk("stuck data", 32'(lastRspData), 32'd25);
        chk("stuck err", 32'(lastRspErr), 32'd1);
        sendCmd(OP_NOP, 12'h000);
        chk("stuck back idle", 32'(lastRspErr), 32'd0);

        // address wrap
        sendCmd(OP_RSTADDR, 12'h000);
        for (int i = 0; i < 511; i++) sendCmd(OP_INC, 12'h000);
        chk("addr top", 32'(pm_addr), 32'h1FF);
        sendCmd(OP_INC, 12'h000);
        chk("addr wrap", 32'(pm_addr), 32'h000);

        // command held valid during PROG must not be taken
        sendCmd(OP_LOAD, 12'h3C3);
        progCmd(1'b1, acc, weUsed);
        chk("hold addr", 32'(pm_addr), 32'h000);
        chk("hold data", 32'(lastRspData), 32'd1);

        // reset in the fourth PULSE cycle
        sendCmd(OP_LOAD, 12'h555);
        cmd_valid = 1'b1;
        cmd_op    = OP_PROG;
        acc       = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        progAcc   = acc;
        progN     = 1;
        cycleCheck();
        nextCycle();
        nextCycle();
        @(posedge clk);
        #2;
        chk("we before abort", 32'(pm_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort pm_we", 32'(pm_we), 32'd0);
        chk("abort core_rst_n", 32'(core_rst_n), 32'd0);
        modelProg  = 1'b0;
        modelAddr  = 0;
        modelLatch = 12'h000;
        progN      = 0;
        expRsp.delete();
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        chk("after abort core_rst_n", 32'(core_rst_n), 32'd1);
        chk("after abort addr", 32'(pm_addr), 32'h000);
        sendCmd(OP_READ, 12'h000);
        chk("after abort in run", 32'(lastRspErr), 32'd1);
        sendCmd(OP_ENTER, 12'h000);
        sendCmd(OP_EXIT, 12'h000);
        chk("exit core_rst_n", 32'(core_rst_n), 32'd1);
        chk("exit err", 32'(lastRspErr), 32'd0);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
